logistic_synth: RTL and testbench
=================================

Name: logistic_synth

Overview:
- Parametrised successor to the single-output logistic-map sound generator.
- Iterates the logistic map x' = r·x·(1−x) in fixed point and retunes N_OSC square-wave phase oscillators from successive x values.
- Sums the oscillators into a multi-bit sample and a 1-bit sigma-delta audio output.
- Adds runtime mode control: ramp, hold, external-r and mute.

Parameters:
N_OSC, 8, number of oscillators (≥1)
ITER_LEN, 15361, clocks per epoch; must satisfy ITER_LEN > N_OSC+1
R_INC, 2, r increment per epoch in ramp mode (Q2.FRAC LSBs)
R_MIN, 3<<FRAC, reset value of r and ramp wrap target
X_SEED, 1<<(FRAC−1), reset value of x and reseed value (nonzero)
FRAC, 16, fractional bits of x and r
PHASE_BITS, 16, phase accumulator width; must satisfy PHASE_BITS ≥ FRAC
FREQ_RES, 0, right shift applied to frequency increments

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mode  in  2  00 ramp, 01 hold, 10 external r, 11 mute
r_ext  in  FRAC+2  external r (Q2.FRAC), used in mode 10
snd  out  1  sigma-delta audio bit
sample  out  $clog2(N_OSC+1)  count of oscillators whose phase MSB is 1
r_cur  out  FRAC+2  current r
epoch_tick  out  1  one-cycle pulse at each epoch start

Behaviour:
- Reset (rst_n low at a clk edge) is synchronous and active-low. It is total and may occur mid-update. It sets:
  - r = R_MIN, x = X_SEED
  - all phases = 0, all increments = 0
  - epoch counter = 0, update index idle
  - sigma-delta acc = 0
  - snd = 0, sample = 0, epoch_tick = 0
- Epoch counter:
  - Counts 0..ITER_LEN−1 and wraps.
  - epoch_tick = 1 in the cycle the counter equals ITER_LEN−1. The first tick falls ITER_LEN−1 cycles after the first cycle with rst_n high.
  - mode is sampled only on the tick; the sampled value holds for the whole epoch.
- Update phase: runs on cycles tick+1 .. tick+N_OSC. On cycle tick+1+k:
  - p = (x·(2^FRAC − x)) >> FRAC
  - xn = (r·p) >> FRAC, saturated to 2^FRAC−1
  - If xn == 0, xn = X_SEED (reseed).
  - x ← xn
  - inc[k] ← (xn << (PHASE_BITS−FRAC)) >> FREQ_RES
- End of update (cycle tick+N_OSC), r update by sampled mode:
  - Ramp: r ← r+R_INC computed at FRAC+3 bits; if the result ≥ 4<<FRAC, r ← R_MIN.
  - Hold: r unchanged.
  - External: r was loaded from r_ext on the tick, before the first iteration, so all iterations of that epoch use r_ext.
  - Mute: no iterations run; x, r and inc are unchanged.
- Oscillators:
  - Every cycle, phase[k] ← phase[k] + inc[k] mod 2^PHASE_BITS, except in mute.
  - A newly loaded inc takes effect on the following cycle.
- Mixer:
  - sample is registered and equals the popcount of the phase MSBs from the previous cycle.
  - In mute, sample = 0.
- Sigma-delta (registered):
  - t = acc + sample
  - If t ≥ N_OSC: snd ← 1, acc ← t − N_OSC. Otherwise snd ← 0, acc ← t.
  - In mute: acc ← 0, snd ← 0.
- r_cur mirrors the r register.
- Muting mid-epoch takes effect only at the next tick.

Test Plan:
All scenarios use N_OSC=2, ITER_LEN=16, FRAC=8, PHASE_BITS=8, R_INC=64, R_MIN=768, X_SEED=128, FREQ_RES=0.
- Reset/first epoch, mode=00:
  - epoch_tick first high at cycle 15.
  - inc[0] = 192 at cycle 16; inc[1] = 144 at cycle 17.
  - r_cur becomes 832 after cycle 17.
  - All outputs are 0 during reset.
- Ramp wrap, mode=00 for 5 epochs: r_cur steps 768 → 832 → 896 → 960 → 768. It never reaches 1024.
- External reseed, mode=10 with r_ext=0 at a tick: both computed xn are 0, so both are reseeded; inc[0] = inc[1] = 128 and r_cur = 0.
- Hold/sigma-delta, mode=01 after epoch 1 (incs 192/144):
  - r_cur stays 832.
  - Over 512 cycles, the number of snd ones equals Σsample/2 within ±1.
  - phase[0] returns to 0 every 4 cycles.
- Mute, mode=11 from a tick: sample and snd are 0 for the whole epoch, and phases are frozen. Returning to mode=00 resumes from the frozen phases and the unchanged r.
- Reset mid-update: rst_n low on cycle tick+1 → all registers return to reset values. The next tick is at cycle 15 after release.

Source files
------------

// File: rtl/logistic_synth.sv
// logistic_synth: logistic-map driven bank of square-wave oscillators.
// Each epoch iterates x' = r*x*(1-x) once per oscillator, retuning that
// oscillator's phase increment, then steps r according to the mode latched
// at the epoch tick. Oscillator MSBs are summed into a multi-bit sample and
// a first-order sigma-delta bit.
module logistic_synth #(
  parameter int FRAC       = 16,
  parameter int N_OSC      = 8,
  parameter int ITER_LEN   = 15361,
  parameter int R_INC      = 2,
  parameter int R_MIN      = 3 << FRAC,
  parameter int X_SEED     = 1 << (FRAC - 1),
  parameter int PHASE_BITS = 16,
  parameter int FREQ_RES   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic [FRAC+1:0]              r_ext,
  output logic                         snd,
  output logic [$clog2(N_OSC+1)-1:0]   sample,
  output logic [FRAC+1:0]              r_cur,
  output logic                         epoch_tick
);

  localparam int SW = $clog2(N_OSC + 1);
  localparam int CW = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;
  localparam int IW = (N_OSC > 1) ? $clog2(N_OSC) : 1;
  localparam int RW = FRAC + 2;

  typedef enum logic [1:0] {
    MODE_RAMP = 2'b00,
    MODE_HOLD = 2'b01,
    MODE_EXT  = 2'b10,
    MODE_MUTE = 2'b11
  } mode_t;

  typedef enum logic {
    UPD_IDLE,
    UPD_RUN
  } upd_t;

  logic [CW-1:0]         cnt;
  mode_t                 mode_q;
  upd_t                  upd_st;
  logic [IW-1:0]         upd_idx;
  logic [RW-1:0]         r;
  logic [FRAC-1:0]       x;
  logic [PHASE_BITS-1:0] inc   [N_OSC];
  logic [PHASE_BITS-1:0] phase [N_OSC];
  logic [SW:0]           acc;
  logic                  mute;

  logic [FRAC:0]         one_minus_x;
  logic [FRAC:0]         p;
  logic [FRAC+2:0]       rp_sh;
  logic [FRAC-1:0]       xn;
  logic [PHASE_BITS-1:0] inc_new;
  logic [FRAC+2:0]       r_sum;
  logic [RW-1:0]         r_next_ramp;
  logic [SW-1:0]         pop;
  logic [SW:0]           sd_t;

  assign mute  = (mode_q == MODE_MUTE);
  assign r_cur = r;

  // Logistic-map step, ramp successor of r, MSB popcount and sigma-delta sum
  always_comb begin
    one_minus_x = {1'b1, {FRAC{1'b0}}} - {1'b0, x};
    p     = (FRAC+1)'(((2*FRAC+1)'(x) * (2*FRAC+1)'(one_minus_x)) >> FRAC);
    rp_sh = (FRAC+3)'(((2*FRAC+3)'(r) * (2*FRAC+3)'(p)) >> FRAC);
    if (|rp_sh[FRAC+2:FRAC]) begin
      xn = '1;
    end else begin
      xn = rp_sh[FRAC-1:0];
    end
    // a zero x is a fixed point of the map, so it is reseeded instead
    if (xn == '0) begin
      xn = FRAC'(X_SEED);
    end
    inc_new = (PHASE_BITS'(xn) << (PHASE_BITS - FRAC)) >> FREQ_RES;

    r_sum = {1'b0, r} + (FRAC+3)'(R_INC);
    if (r_sum >= ((FRAC+3)'(4) << FRAC)) begin
      r_next_ramp = RW'(R_MIN);
    end else begin
      r_next_ramp = r_sum[RW-1:0];
    end

    pop = '0;
    for (int unsigned k = 0; k < N_OSC; k++) begin
      pop = pop + SW'(phase[k][PHASE_BITS-1]);
    end

    sd_t = acc + (SW+1)'(sample);
  end

  // Epoch counter, mode latch and per-oscillator update sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      epoch_tick <= 1'b0;
      mode_q     <= MODE_RAMP;
      upd_st     <= UPD_IDLE;
      upd_idx    <= '0;
      r          <= RW'(R_MIN);
      x          <= FRAC'(X_SEED);
    end else begin
      cnt        <= (cnt == CW'(ITER_LEN - 1)) ? '0 : cnt + 1'b1;
      // registered one cycle early so the pulse lines up with cnt == ITER_LEN-1
      epoch_tick <= (cnt == CW'(ITER_LEN - 2));
      if (epoch_tick) begin
        mode_q <= mode_t'(mode);
        if (mode_t'(mode) == MODE_EXT) begin
          r <= r_ext;
        end
        if (mode_t'(mode) != MODE_MUTE) begin
          upd_st  <= UPD_RUN;
          upd_idx <= '0;
        end
      end else if (upd_st == UPD_RUN) begin
        x <= xn;
        if (upd_idx == IW'(N_OSC - 1)) begin
          upd_st <= UPD_IDLE;
          if (mode_q == MODE_RAMP) begin
            r <= r_next_ramp;
          end
        end else begin
          upd_idx <= upd_idx + 1'b1;
        end
      end
    end
  end

  // Load the freshly iterated increment into the oscillator being updated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_OSC; k++) begin
        inc[k] <= '0;
      end
    end else if (upd_st == UPD_RUN) begin
      for (int unsigned k = 0; k < N_OSC; k++) begin
        if (upd_idx == IW'(k)) begin
          inc[k] <= inc_new;
        end
      end
    end
  end

  // Phase accumulators, frozen while muted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_OSC; k++) begin
        phase[k] <= '0;
      end
    end else if (!mute) begin
      for (int unsigned k = 0; k < N_OSC; k++) begin
        phase[k] <= phase[k] + inc[k];
      end
    end
  end

  // Registered mixer sample and first-order sigma-delta modulator
  always_ff @(posedge clk) begin
    if (!rst_n || mute) begin
      sample <= '0;
      acc    <= '0;
      snd    <= 1'b0;
    end else begin
      sample <= pop;
      if (sd_t >= (SW+1)'(N_OSC)) begin
        snd <= 1'b1;
        acc <= sd_t - (SW+1)'(N_OSC);
      end else begin
        snd <= 1'b0;
        acc <= sd_t;
      end
    end
  end

endmodule

// File: tb/tb_logistic_synth.sv
// tb_logistic_synth: directed checks of logistic_synth with a small
// configuration (2 oscillators, 16-cycle epochs, 8 fractional bits).
module tb_logistic_synth;

  localparam int FRAC = 8;

  logic            clk;
  logic            rst_n;
  logic [1:0]      mode;
  logic [FRAC+1:0] r_ext;
  logic            snd;
  logic [1:0]      sample;
  logic [FRAC+1:0] r_cur;
  logic            epoch_tick;

  int total;
  int bad;
  int cyc;

  logistic_synth #(
    .FRAC       (FRAC),
    .N_OSC      (2),
    .ITER_LEN   (16),
    .R_INC      (64),
    .R_MIN      (768),
    .X_SEED     (128),
    .PHASE_BITS (8),
    .FREQ_RES   (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .r_ext      (r_ext),
    .snd        (snd),
    .sample     (sample),
    .r_cur      (r_cur),
    .epoch_tick (epoch_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // advance to the negedge of cycle n (cycle 0 = first cycle after release)
  task automatic go_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_snd", int'(snd), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_tick", int'(epoch_tick), 0);
    check("rst_r", int'(r_cur), 768);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
  endtask

  int ph0_frozen;
  int ph1_frozen;
  int nz;
  int r_bad;
  int s_sum;
  int ones;
  int diff;

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    mode  = 2'b00;
    r_ext = '0;

    // ramp mode: first epoch detail, then r wrap over successive epochs
    do_reset();
    for (int c = 14; c <= 66; c++) begin
      go_to(c);
      case (c)
        14: check("tick_c14", int'(epoch_tick), 0);
        15: check("tick_c15", int'(epoch_tick), 1);
        16: check("tick_c16", int'(epoch_tick), 0);
        17: begin
          check("inc0_first", int'(dut.inc[0]), 192);
          check("ph0_c17", int'(dut.phase[0]), 0);
          check("r_c17", int'(r_cur), 768);
        end
        18: begin
          check("inc1_first", int'(dut.inc[1]), 144);
          check("r_c18", int'(r_cur), 832);
          check("sample_c18", int'(sample), 0);
          check("ph0_c18", int'(dut.phase[0]), 192);
        end
        19: begin
          check("sample_c19", int'(sample), 1);
          check("snd_c19", int'(snd), 0);
        end
        20: begin
          check("sample_c20", int'(sample), 2);
          check("snd_c20", int'(snd), 0);
        end
        21: begin
          check("sample_c21", int'(sample), 0);
          check("snd_c21", int'(snd), 1);
          check("ph0_c21", int'(dut.phase[0]), 0);
        end
        22: begin
          check("sample_c22", int'(sample), 1);
          check("snd_c22", int'(snd), 0);
        end
        23: check("snd_c23", int'(snd), 1);
        25: check("ph0_c25", int'(dut.phase[0]), 0);
        29: check("ph0_c29", int'(dut.phase[0]), 0);
        31: check("tick_c31", int'(epoch_tick), 1);
        33: check("ph0_c33", int'(dut.phase[0]), 0);
        34: check("r_ramp2", int'(r_cur), 896);
        50: check("r_ramp3", int'(r_cur), 960);
        65: check("r_ramp3_end", int'(r_cur), 960);
        66: check("r_wrap", int'(r_cur), 768);
        default: ;
      endcase
    end

    // external r = 0: both iterations collapse to zero and are reseeded
    mode  = 2'b10;
    r_ext = '0;
    do_reset();
    go_to(16);
    check("ext_r_load", int'(r_cur), 0);
    go_to(17);
    check("ext_inc0", int'(dut.inc[0]), 128);
    go_to(18);
    check("ext_inc1", int'(dut.inc[1]), 128);
    check("ext_r_kept", int'(r_cur), 0);

    // hold from the second epoch: r frozen, sigma-delta density tracks sample
    mode = 2'b00;
    do_reset();
    go_to(20);
    mode  = 2'b01;
    r_bad = 0;
    s_sum = 0;
    ones  = 0;
    for (int c = 34; c <= 552; c++) begin
      go_to(c);
      if (r_cur != 10'd832) r_bad++;
      if (c >= 40 && c <= 551) s_sum += int'(sample);
      if (c >= 41) ones += int'(snd);
    end
    check("hold_r", r_bad, 0);
    check("hold_r_end", int'(r_cur), 832);
    check("hold_active", int'(s_sum > 0), 1);
    diff = ones - s_sum / 2;
    if (diff < 0) diff = -diff;
    check("sd_density", int'(diff <= 1), 1);

    // mute for one epoch, then resume ramping from frozen state
    mode = 2'b00;
    do_reset();
    go_to(20);
    mode = 2'b11;
    go_to(32);
    ph0_frozen = int'(dut.phase[0]);
    ph1_frozen = int'(dut.phase[1]);
    check("mute_ph0_start", ph0_frozen, 64);
    check("mute_ph1_start", ph1_frozen, 224);
    nz = 0;
    for (int c = 33; c <= 48; c++) begin
      go_to(c);
      if (c == 40) mode = 2'b00;
      if (sample != 2'd0 || snd != 1'b0) nz++;
    end
    check("mute_quiet", nz, 0);
    check("mute_ph0_frozen", int'(dut.phase[0]), ph0_frozen);
    check("mute_ph1_frozen", int'(dut.phase[1]), ph1_frozen);
    check("mute_r_kept", int'(r_cur), 832);
    go_to(49);
    check("unmute_ph0", int'(dut.phase[0]), 0);
    go_to(50);
    check("unmute_r", int'(r_cur), 896);

    // reset asserted in the first update cycle of an epoch
    mode = 2'b00;
    do_reset();
    go_to(16);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
    check("midrst_inc0", int'(dut.inc[0]), 0);
    check("midrst_r", int'(r_cur), 768);
    check("midrst_sample", int'(sample), 0);
    check("midrst_snd", int'(snd), 0);
    check("midrst_tick", int'(epoch_tick), 0);
    go_to(14);
    check("midrst_tick_c14", int'(epoch_tick), 0);
    go_to(15);
    check("midrst_tick_c15", int'(epoch_tick), 1);
    go_to(17);
    check("midrst_inc0_again", int'(dut.inc[0]), 192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
